// File: rtl/vec_ser_pkg.sv
// Shared types and default sizing for the vector-to-memory serializer.
package vec_ser_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_LANES  = 16;
    localparam int unsigned DEF_ADDR_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/vec_ser_addr_gen.sv
// Beat/lane sequencing for the serializer: beat counter, lane index up/down
// counter, base+beat address and last-beat flag. Outputs next-cycle values.
module vec_ser_addr_gen
    import vec_ser_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    localparam int unsigned CNT_W = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reverse_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              advance,
    output logic [CNT_W-1:0]  idx_nxt_c,
    output logic [ADDR_W-1:0] addr_nxt_c,
    output logic              last_c
);

    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rev_q, rev_d;

    always_comb begin
        beat_d = beat_q;
        idx_d  = idx_q;
        base_d = base_q;
        rev_d  = rev_q;
        if (start) begin
            beat_d = '0;
            idx_d  = reverse_i ? CNT_W'(LANES - 1) : '0;
            base_d = base_i;
            rev_d  = reverse_i;
        end else if (advance) begin
            beat_d = beat_q + CNT_W'(1);
            idx_d  = rev_q ? (idx_q - CNT_W'(1)) : (idx_q + CNT_W'(1));
        end
    end

    // Address always ascends from base; lane order only affects idx.
    assign idx_nxt_c  = idx_d;
    assign addr_nxt_c = base_d + ADDR_W'(beat_d);
    assign last_c     = (beat_q == CNT_W'(LANES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            idx_q  <= '0;
            base_q <= '0;
            rev_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            idx_q  <= idx_d;
            base_q <= base_d;
            rev_q  <= rev_d;
        end
    end

endmodule

// File: rtl/vec_mem_serializer.sv
// Accepts a LANES x DATA_W vector and writes it to memory one lane per beat
// at ascending addresses from a base, honouring memory back-pressure.
module vec_mem_serializer
    import vec_ser_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0]       in_base_addr,
    input  logic                    in_reverse,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W = $clog2(LANES);

    state_t                        state_q, state_d;
    logic [LANES-1:0][DATA_W-1:0]  buf_q, buf_d;
    logic [LANES-1:0][DATA_W-1:0]  in_vec;
    logic                          in_ready_q, in_ready_d;
    logic                          busy_q, busy_d;
    logic                          mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]             mem_wdata_q, mem_wdata_d;
    logic                          done_q, done_d;
    logic                          start, advance;
    logic [CNT_W-1:0]              idx_nxt;
    logic [ADDR_W-1:0]             addr_nxt;
    logic                          last;

    assign in_vec = in_data;

    vec_ser_addr_gen #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reverse_i  (in_reverse),
        .base_i     (in_base_addr),
        .advance    (advance),
        .idx_nxt_c  (idx_nxt),
        .addr_nxt_c (addr_nxt),
        .last_c     (last)
    );

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        start       = 1'b0;
        advance     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                mem_we_d   = 1'b0;
                if (in_valid && in_ready_q) begin
                    start       = 1'b1;
                    buf_d       = in_vec;
                    state_d     = SEND;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_nxt;
                    mem_wdata_d = in_vec[idx_nxt];
                end
            end
            SEND: begin
                if (mem_ready) begin
                    advance = 1'b1;
                    if (last) begin
                        state_d    = IDLE;
                        mem_we_d   = 1'b0;
                        busy_d     = 1'b0;
                        in_ready_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        mem_addr_d  = addr_nxt;
                        mem_wdata_d = buf_q[idx_nxt];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vec_mem_serializer.sv
// Scoreboard bench for vec_mem_serializer: stimulus pushes expected writes,
// a negedge monitor pops and compares every accepted memory write.
module tb_vec_mem_serializer;

    localparam int DATA_W = 16;
    localparam int LANES  = 16;
    localparam int ADDR_W = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data = '0;
    logic [ADDR_W-1:0]       in_base_addr = '0;
    logic                    in_reverse = 1'b0;
    logic                    mem_we;
    logic                    mem_ready = 1'b1;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    busy;
    logic                    done;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          beats_acc = 0;
    logic        hold_pend = 1'b0;
    logic [15:0] hold_addr = '0;
    logic [15:0] hold_data = '0;

    always #5 clk = ~clk;

    vec_mem_serializer #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_base_addr (in_base_addr),
        .in_reverse   (in_reverse),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        else
            n_pass++;
    endtask

    // Monitor: compare accepted writes against the scoreboard; stalled beats must hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_addr", 32'(mem_addr), 32'(hold_addr));
                chk("hold_data", 32'(mem_wdata), 32'(hold_data));
                chk("hold_we", 32'(mem_we), 32'd1);
                hold_pend = 1'b0;
            end
            if (mem_we && mem_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
                end else begin
                    chk("write", {mem_addr, mem_wdata}, exp_q.pop_front());
                end
                beats_acc++;
            end else if (mem_we) begin
                hold_pend = 1'b1;
                hold_addr = mem_addr;
                hold_data = mem_wdata;
            end
        end
    end

    task automatic run_vec(input logic [15:0] base, input logic rev, input int stall_beat,
                           input int stall_len, input int abort_beat, input int exp_cyc,
                           input bit junk);
        int cyc;
        int stall_left;
        bit seen_done;
        logic [15:0] a;
        logic [15:0] d;
        stall_left = stall_len;
        seen_done  = 1'b0;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        for (int k = 0; k < LANES; k++) begin
            a = base + 16'(k);
            d = rev ? 16'(16'h1000 + LANES - 1 - k) : 16'(16'h1000 + k);
            exp_q.push_back({a, d});
        end
        for (int i = 0; i < LANES; i++) in_data[i*DATA_W +: DATA_W] = 16'(16'h1000 + i);
        in_base_addr = base;
        in_reverse   = rev;
        in_valid     = 1'b1;
        mem_ready    = 1'b1;
        beats_acc    = 0;
        @(posedge clk);
        #1;
        in_valid     = junk;
        in_data      = ~in_data;
        in_base_addr = 16'h5555;
        in_reverse   = ~rev;
        for (cyc = 1; cyc <= 60; cyc++) begin
            if (abort_beat >= 0 && beats_acc == abort_beat) begin
                rst = 1'b1;
                exp_q.delete();
                #2;
                chk("abort_we", 32'(mem_we), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                chk("abort_in_ready", 32'(in_ready), 32'd1);
                chk("abort_idle_we", 32'(mem_we), 32'd0);
                return;
            end
            if (beats_acc >= 10) in_valid = 1'b0;
            if (beats_acc == stall_beat && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("done_latency", 32'(cyc), 32'(exp_cyc));
        chk("beat_count", 32'(beats_acc), 32'(LANES));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("in_ready_at_done", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("we_after_done", 32'(mem_we), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_addr", 32'(mem_addr), 32'd0);
        chk("rel_wdata", 32'(mem_wdata), 32'd0);

        run_vec(16'h0040, 1'b0, -1, 0, -1, LANES + 1, 1'b1);
        run_vec(16'h0040, 1'b1, -1, 0, -1, LANES + 1, 1'b0);
        run_vec(16'h0040, 1'b0, 5, 3, -1, LANES + 4, 1'b0);
        run_vec(16'hFFFE, 1'b0, -1, 0, -1, LANES + 1, 1'b0);
        run_vec(16'h0100, 1'b0, -1, 0, 7, 0, 1'b0);
        run_vec(16'h0200, 1'b0, -1, 0, -1, LANES + 1, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
